// File: rtl/arcade_inputs_pkg.sv
// rtl/arcade_inputs_pkg.sv - shared constants and types for the arcade player-input front end
// Joystick bit map, PS/2 scancodes ({extended, code}), coin FSM states and the DIP download index.
package arcade_inputs_pkg;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_BOMB   = 5;
  localparam int JOY_START  = 6;
  localparam int JOY_SELECT = 7;
  localparam int JOY_COIN   = 8;
  localparam int JOY_PAUSE  = 9;

  // Per-player key tables; only players 1 and 2 have direction/fire keys.
  localparam logic [8:0] KEY_UP    [2] = '{9'h075, 9'h02D};
  localparam logic [8:0] KEY_LEFT  [2] = '{9'h06B, 9'h023};
  localparam logic [8:0] KEY_DOWN  [2] = '{9'h072, 9'h02B};
  localparam logic [8:0] KEY_RIGHT [2] = '{9'h074, 9'h034};
  localparam logic [8:0] KEY_FIRE  [2] = '{9'h014, 9'h01C};
  localparam logic [8:0] KEY_BOMB  [2] = '{9'h011, 9'h01B};
  localparam logic [8:0] KEY_START [4] = '{9'h016, 9'h01E, 9'h026, 9'h025};
  localparam logic [8:0] KEY_COIN  [4] = '{9'h02E, 9'h036, 9'h03D, 9'h03E};
  localparam logic [8:0] KEY_SERVICE  = 9'h046;
  localparam logic [8:0] KEY_F3_RESET = 9'h004;

  localparam logic [7:0] DSW_INDEX = 8'd254;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    WAIT_REL
  } coin_state_t;

  // Arrow keys arrive with or without the extended prefix depending on keypad use.
  function automatic logic key_match(input logic [8:0] key, input logic [8:0] code,
                                     input logic any_ext);
    return (key[7:0] == code[7:0]) && (any_ext || (key[8] == code[8]));
  endfunction

endpackage

// File: rtl/arcade_coin_pulse.sv
// rtl/arcade_coin_pulse.sv - fixed-width coin pulse with release lockout
// One pulse of COIN_CYCLES cycles per press; the input must drop before another pulse can start.
module arcade_coin_pulse
  import arcade_inputs_pkg::*;
#(
  parameter int COIN_CYCLES = 60000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(COIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(COIN_CYCLES - 1);

  coin_state_t   state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (raw) begin
            state <= ACTIVE;
            cnt   <= CNT_LOAD;
            pulse <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cnt == '0) begin
            state <= WAIT_REL;
            pulse <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WAIT_REL: begin
          if (!raw) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arcade_inputs.sv
// rtl/arcade_inputs.sv - merges PS/2 keys and joysticks into registered player controls
// Also generates coin pulses, per-player autofire and captures DIP bytes from the ioctl stream.
module arcade_inputs
  import arcade_inputs_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_DSW     = 2,
  parameter int COIN_CYCLES = 60000,
  parameter int AF_HALF     = 400000
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [10:0]              ps2_key,
  input  logic [16*NUM_PLAYERS-1:0] joystick,
  input  logic                     ioctl_wr,
  input  logic [7:0]               ioctl_index,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  input  logic [NUM_PLAYERS-1:0]   autofire_en,
  output logic [NUM_PLAYERS-1:0]   up,
  output logic [NUM_PLAYERS-1:0]   down,
  output logic [NUM_PLAYERS-1:0]   left,
  output logic [NUM_PLAYERS-1:0]   right,
  output logic [NUM_PLAYERS-1:0]   fire,
  output logic [NUM_PLAYERS-1:0]   bomb,
  output logic [NUM_PLAYERS-1:0]   start,
  output logic [NUM_PLAYERS-1:0]   coin,
  output logic                     service,
  output logic                     key_reset,
  output logic                     pause_btn,
  output logic [8*NUM_DSW-1:0]     dsw,
  output logic                     dsw_valid
);

  localparam int AFW = $clog2(AF_HALF + 1);
  localparam logic [AFW-1:0] AF_LAST = AFW'(AF_HALF - 1);

  // Key latches and DIP state keep power-up values only; game reset must not disturb them.
  logic       old_tgl   = 1'b0;
  logic       k_service = 1'b0;
  logic       k_reset   = 1'b0;
  logic       key_evt;
  logic [8:0] key_code;

  assign key_evt  = old_tgl != ps2_key[10];
  assign key_code = ps2_key[8:0];

  always_ff @(posedge clk_sys) begin
    old_tgl <= ps2_key[10];
    if (key_evt) begin
      if (key_code == KEY_SERVICE)  k_service <= ps2_key[9];
      if (key_code == KEY_F3_RESET) k_reset   <= ps2_key[9];
    end
  end

  logic [NUM_PLAYERS-1:0] pause_raw;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [15:0] joy;
    logic [5:0]  key_ctl;
    logic        k_start = 1'b0;
    logic        k_coin  = 1'b0;
    logic        select_in;
    logic        unused_joy;

    assign joy          = joystick[16*p +: 16];
    assign pause_raw[p] = joy[JOY_PAUSE];
    assign unused_joy   = ^{joy[15:10], joy[JOY_SELECT]};

    always_ff @(posedge clk_sys) begin
      if (key_evt) begin
        if (key_code == KEY_START[p]) k_start <= ps2_key[9];
        if (key_code == KEY_COIN[p])  k_coin  <= ps2_key[9];
      end
    end

    // key_ctl = {bomb, fire, up, down, left, right}
    if (p < 2) begin : g_keys
      logic [5:0] k_ctl = '0;
      always_ff @(posedge clk_sys) begin
        if (key_evt) begin
          if (key_match(key_code, KEY_RIGHT[p], p == 0)) k_ctl[0] <= ps2_key[9];
          if (key_match(key_code, KEY_LEFT[p],  p == 0)) k_ctl[1] <= ps2_key[9];
          if (key_match(key_code, KEY_DOWN[p],  p == 0)) k_ctl[2] <= ps2_key[9];
          if (key_match(key_code, KEY_UP[p],    p == 0)) k_ctl[3] <= ps2_key[9];
          if (key_match(key_code, KEY_FIRE[p],  1'b0))   k_ctl[4] <= ps2_key[9];
          if (key_match(key_code, KEY_BOMB[p],  1'b0))   k_ctl[5] <= ps2_key[9];
        end
      end
      assign key_ctl = k_ctl;
    end else begin : g_no_keys
      assign key_ctl = '0;
    end

    // Select of the previous player acts as this player's start.
    if (NUM_PLAYERS > 1) begin : g_sel
      assign select_in = joystick[16*((p + NUM_PLAYERS - 1) % NUM_PLAYERS) + JOY_SELECT];
    end else begin : g_no_sel
      assign select_in = 1'b0;
    end

    logic raw_right, raw_left, raw_down, raw_up, raw_fire, raw_bomb, raw_start, raw_coin;

    assign raw_right = joy[JOY_RIGHT] | key_ctl[0];
    assign raw_left  = joy[JOY_LEFT]  | key_ctl[1];
    assign raw_down  = joy[JOY_DOWN]  | key_ctl[2];
    assign raw_up    = joy[JOY_UP]    | key_ctl[3];
    assign raw_fire  = joy[JOY_FIRE]  | key_ctl[4];
    assign raw_bomb  = joy[JOY_BOMB]  | key_ctl[5];
    assign raw_start = joy[JOY_START] | k_start | select_in;
    assign raw_coin  = joy[JOY_COIN]  | k_coin;

    arcade_coin_pulse #(
      .COIN_CYCLES(COIN_CYCLES)
    ) u_coin (
      .clk_sys(clk_sys),
      .reset  (reset),
      .raw    (raw_coin),
      .pulse  (coin[p])
    );

    logic [AFW-1:0] af_cnt;
    logic [AFW-1:0] af_cnt_n;
    logic           af_phase;
    logic           af_phase_n;
    logic           fire_prev;
    logic [6:0]     ctl_q;

    // Autofire runs regardless of enable so toggling it mid-hold keeps the current phase.
    always_comb begin
      af_cnt_n   = af_cnt;
      af_phase_n = af_phase;
      if (raw_fire && !fire_prev) begin
        af_cnt_n   = '0;
        af_phase_n = 1'b1;
      end else if (raw_fire) begin
        if (af_cnt == AF_LAST) begin
          af_cnt_n   = '0;
          af_phase_n = ~af_phase;
        end else begin
          af_cnt_n = af_cnt + AFW'(1);
        end
      end else begin
        af_cnt_n   = '0;
        af_phase_n = 1'b0;
      end
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        af_cnt    <= '0;
        af_phase  <= 1'b0;
        fire_prev <= 1'b0;
        ctl_q     <= '0;
      end else begin
        af_cnt    <= af_cnt_n;
        af_phase  <= af_phase_n;
        fire_prev <= raw_fire;
        ctl_q     <= {raw_start, raw_bomb,
                      autofire_en[p] ? (raw_fire & af_phase_n) : raw_fire,
                      raw_up, raw_down, raw_left, raw_right};
      end
    end

    assign right[p] = ctl_q[0];
    assign left[p]  = ctl_q[1];
    assign down[p]  = ctl_q[2];
    assign up[p]    = ctl_q[3];
    assign fire[p]  = ctl_q[4];
    assign bomb[p]  = ctl_q[5];
    assign start[p] = ctl_q[6];
  end

  logic pause_q;
  logic service_q;
  logic key_reset_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pause_q     <= 1'b0;
      service_q   <= 1'b0;
      key_reset_q <= 1'b0;
    end else begin
      pause_q     <= |pause_raw;
      service_q   <= k_service;
      key_reset_q <= k_reset;
    end
  end

  assign pause_btn = pause_q;
  assign service   = service_q;
  assign key_reset = key_reset_q;

  // DIP bytes are kept inverted so a download of 0 means every switch is on.
  logic [8*NUM_DSW-1:0] dsw_q       = '1;
  logic                 dsw_valid_q = 1'b0;
  logic                 dsw_wr;

  assign dsw_wr = ioctl_wr && (ioctl_index == DSW_INDEX) && (ioctl_addr < 25'(NUM_DSW));

  always_ff @(posedge clk_sys) begin
    if (dsw_wr) begin
      for (int n = 0; n < NUM_DSW; n++) begin
        if (ioctl_addr == 25'(n)) dsw_q[8*n +: 8] <= ~ioctl_dout;
      end
      if (ioctl_addr == 25'(NUM_DSW - 1)) dsw_valid_q <= 1'b1;
    end
  end

  assign dsw       = dsw_q;
  assign dsw_valid = dsw_valid_q;

endmodule

// File: tb/tb_arcade_inputs.sv
// tb/tb_arcade_inputs.sv - self-checking bench for arcade_inputs
// Two players, two DIP bytes, COIN_CYCLES=4, AF_HALF=3; inputs driven and outputs sampled on negedge.
module tb_arcade_inputs;

  logic        clk_sys     = 1'b0;
  logic        reset       = 1'b1;
  logic [10:0] ps2_key     = '0;
  logic [31:0] joystick    = '0;
  logic        ioctl_wr    = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic [24:0] ioctl_addr  = '0;
  logic [7:0]  ioctl_dout  = '0;
  logic [1:0]  autofire_en = '0;
  logic [1:0]  up, down, left, right, fire, bomb, start, coin;
  logic        service, key_reset, pause_btn;
  logic [15:0] dsw;
  logic        dsw_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_inputs #(
    .NUM_PLAYERS(2),
    .NUM_DSW    (2),
    .COIN_CYCLES(4),
    .AF_HALF    (3)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joystick   (joystick),
    .ioctl_wr   (ioctl_wr),
    .ioctl_index(ioctl_index),
    .ioctl_addr (ioctl_addr),
    .ioctl_dout (ioctl_dout),
    .autofire_en(autofire_en),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .fire       (fire),
    .bomb       (bomb),
    .start      (start),
    .coin       (coin),
    .service    (service),
    .key_reset  (key_reset),
    .pause_btn  (pause_btn),
    .dsw        (dsw),
    .dsw_valid  (dsw_valid)
  );

  typedef struct {
    logic [31:0] joy;
    logic [14:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic ps2_event(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic dsw_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    ioctl_wr    = 1'b1;
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = data;
    tick(1);
    ioctl_wr    = 1'b0;
  endtask

  // {pause, start, bomb, fire, up, down, left, right}
  function automatic logic [14:0] mk(input logic pa, input logic [1:0] st, input logic [1:0] bo,
                                     input logic [1:0] fi, input logic [1:0] u, input logic [1:0] d,
                                     input logic [1:0] l, input logic [1:0] r);
    return {pa, st, bo, fi, u, d, l, r};
  endfunction

  vec_t       vecs [11];
  logic [11:0] af_pat;

  initial begin
    vecs[0]  = '{32'h0000_0000, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[1]  = '{32'h0000_0001, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01)};
    vecs[2]  = '{32'h0000_000A, mk(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00)};
    vecs[3]  = '{32'h0004_0004, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00)};
    vecs[4]  = '{32'h0030_0000, mk(0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[5]  = '{32'h0000_0080, mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[6]  = '{32'h0080_0040, mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[7]  = '{32'h0200_0000, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[8]  = '{32'h0000_0200, mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    vecs[9]  = '{32'h0001_0002, mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10)};
    vecs[10] = '{32'h00C0_0080, mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00)};
    af_pat   = 12'b111000111000;

    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_ctl", {16'h0, coin, start, bomb, fire, up, down, left, right}, 32'h0);
    check("reset_misc", {service, key_reset, pause_btn, dsw_valid}, 4'b0000);
    check("reset_dsw", dsw, 16'hFFFF);

    for (int i = 0; i < 11; i++) begin
      joystick = vecs[i].joy;
      tick(1);
      check($sformatf("vec%0d", i),
            {pause_btn, start, bomb, fire, up, down, left, right}, vecs[i].exp);
    end
    joystick = '0;
    tick(2);

    // Held coin: one 4-cycle pulse, no re-fire
    joystick = 32'h0000_0100;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      check($sformatf("coin_hold%0d", i), coin, (i <= 4) ? 2'b01 : 2'b00);
    end
    joystick = '0;
    tick(2);
    check("coin_released", coin, 2'b00);
    joystick = 32'h0000_0100;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check($sformatf("coin_again%0d", i), coin, (i <= 4) ? 2'b01 : 2'b00);
    end
    joystick = '0;
    tick(2);

    // PS/2 up: press plain, release with extended prefix
    ps2_event(1'b1, 1'b0, 8'h75);
    tick(1);
    check("ps2_up_lat", up, 2'b00);
    tick(1);
    check("ps2_up_on", up, 2'b01);
    tick(3);
    ps2_event(1'b0, 1'b1, 8'h75);
    tick(1);
    check("ps2_up_hold", up, 2'b01);
    tick(1);
    check("ps2_up_off", up, 2'b00);
    ps2_event(1'b1, 1'b0, 8'h1C);
    tick(2);
    check("ps2_p2_fire", fire, 2'b10);
    ps2_event(1'b0, 1'b0, 8'h1C);
    tick(2);
    check("ps2_p2_fire_off", fire, 2'b00);
    tick(1);

    // Autofire on player 2
    autofire_en = 2'b10;
    joystick    = 32'h0010_0000;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      check($sformatf("af_on%0d", i), fire, {af_pat[12-i], 1'b0});
    end
    joystick = '0;
    tick(1);
    check("af_release", fire, 2'b00);
    autofire_en = 2'b00;
    tick(1);
    joystick = 32'h0010_0000;
    check("af_off_lag", fire, 2'b00);
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      check($sformatf("af_off%0d", i), fire, 2'b10);
    end
    joystick = '0;
    tick(2);

    // DIP capture
    dsw_write(8'd254, 25'd0, 8'h0F);
    check("dsw_b0", dsw, 16'hFFF0);
    check("dsw_b0_valid", dsw_valid, 1'b0);
    dsw_write(8'd254, 25'd1, 8'hA5);
    check("dsw_b1", dsw, 16'h5AF0);
    check("dsw_b1_valid", dsw_valid, 1'b1);
    dsw_write(8'd254, 25'd2, 8'h00);
    check("dsw_addr2", dsw, 16'h5AF0);
    dsw_write(8'd0, 25'd0, 8'h00);
    check("dsw_idx0", dsw, 16'h5AF0);

    // Reset mid coin pulse with F3 held
    ps2_event(1'b1, 1'b0, 8'h04);
    tick(2);
    check("f3_on", key_reset, 1'b1);
    joystick = 32'h0000_0100;
    tick(1);
    check("rst_coin_c1", coin, 2'b01);
    tick(1);
    check("rst_coin_c2", coin, 2'b01);
    reset = 1'b1;
    tick(1);
    check("rst_coin_drop", coin, 2'b00);
    check("rst_keyreset_clr", key_reset, 1'b0);
    reset = 1'b0;
    tick(1);
    check("rst_coin_restart", coin, 2'b01);
    check("rst_keyreset_kept", key_reset, 1'b1);
    check("rst_dsw_kept", dsw, 16'h5AF0);
    check("rst_dsw_valid_kept", dsw_valid, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      tick(1);
      check($sformatf("rst_coin_c%0d", i), coin, (i <= 4) ? 2'b01 : 2'b00);
    end
    joystick = '0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
